seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter W, default 6, operand width in bits (W >= 4).
REQ-002 SHALL have parameter LIMIT, default 9999, largest reportable result magnitude.
REQ-003 SHALL have ports:
- clk  input  1  clock. One clock; all logic on its rising edge.
- rst  input  1  reset. Synchronous, active-high.
- start  input  1  request to begin an operation.
- op  input  3  operation code.
- sgn  input  1  signed mode: operands are two's complement when 1.
- a  input  W  operand A.
- b  input  W  operand B.
- busy  output  1  operation in progress.
- done  output  1  one-cycle completion pulse.
- result  output  2W  result magnitude.
- neg  output  1  result is negative.
- ovf  output  1  overflow.
- err  output  1  illegal operation.

Function
REQ-004 SHALL decode op as follows: 000 add, 001 sub, 010 mul, 011 div, 100 mod, 101 shift right A by B, 110 shift left A by B, 111 factorial of A.
REQ-005 SHALL use three states:
- IDLE: busy=0, done=0.
- CALC: busy=1, done=0.
- FIN: busy=0, done=1, exactly one cycle; then IDLE.
REQ-006 SHALL accept start only in IDLE or FIN, latching op, sgn, a and b on the accepting edge, then entering CALC; start in CALC SHALL be ignored.
REQ-007 SHALL hold CALC for N cycles, then FIN:
- N=1 for add, sub, shifts and every err case.
- N=W for mul, div and mod.
- N=max(|A|-1,1) for factorial, ending early on the cycle the partial product exceeds LIMIT.
REQ-008 SHALL implement mul as iterative shift-add and div/mod as iterative restoring division on operand magnitudes, one bit per cycle.
REQ-009 SHALL set signs in signed mode as follows: mul/div sign = sign(A) XOR sign(B); mod sign = sign(A); add/sub computed at W+1 bits signed.
REQ-010 SHALL set neg=0 for every result in unsigned mode.
REQ-011 SHALL perform shift right as arithmetic in signed mode and logical otherwise, with B treated unsigned; B=0 SHALL return A.
REQ-012 SHALL fill the shifted result with sign bits when B >= W (signed right shift) and with zeros in all other B >= W cases.
REQ-013 SHALL compute shift left at 2W bits.
REQ-014 SHALL give factorial 0! = 1! = 1.
REQ-015 SHALL set err=1, result=0 and neg=0 for div or mod with B=0, and for factorial with negative A in signed mode.
REQ-016 SHALL set ovf=1, result=0 and neg=0 when the final magnitude exceeds LIMIT; err SHALL take priority, giving ovf=0 whenever err=1.
REQ-017 SHALL present result as a magnitude, with neg=1 only when the magnitude is nonzero.
REQ-018 SHALL update result, neg, ovf and err on the edge entering FIN and hold them until the next FIN.
REQ-019 SHALL, when start is accepted in FIN, produce no bubble: CALC follows FIN directly.

Reset
REQ-020 SHALL, while rst=1, force state IDLE and busy, done, result, neg, ovf and err to 0.
REQ-021 SHALL give rst priority over start.
REQ-022 SHALL, when rst asserts during CALC, abandon the operation with no done pulse.

Verification
REQ-023 SHALL cover unsigned add: W=6, sgn=0, a=63, b=63, start at cycle 0 -> done at cycle 2, result=126, neg=0.
REQ-024 SHALL cover signed mul: a=-5, b=7, sgn=1 -> done at cycle 7, result=35, neg=1, ovf=0.
REQ-025 SHALL cover signed div and mod: a=-17, b=5 -> div gives result=3, neg=1; mod gives result=2, neg=1.
REQ-026 SHALL cover the error case: div a=9, b=0 -> err=1, result=0, done at cycle 2.
REQ-027 SHALL cover factorial: a=7 -> result=5040, ovf=0; a=8 -> ovf=1, result=0.
REQ-028 SHALL cover start and reset during CALC: start during mul CALC is ignored and the first result is unchanged; rst at CALC cycle 3 -> busy=0 next cycle and done never pulses.

Source files
------------

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle add/sub/shift, iterative shift-add multiply,
// restoring divide/modulo and a factorial that stops once it passes LIMIT.
module seq_alu #(
   parameter int W     = 6,
   parameter int LIMIT = 9999
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [2:0]     op,
   input  logic           sgn,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] result,
   output logic           neg,
   output logic           ovf,
   output logic           err
);
   localparam int LW = $clog2(LIMIT + 1);
   localparam int AW = ((LW > 2*W) ? LW : 2*W) + W;
   localparam int CW = W + 1;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_MUL  = 3'd2;
   localparam logic [2:0] OP_DIV  = 3'd3;
   localparam logic [2:0] OP_MOD  = 3'd4;
   localparam logic [2:0] OP_SHR  = 3'd5;
   localparam logic [2:0] OP_SHL  = 3'd6;
   localparam logic [2:0] OP_FACT = 3'd7;

   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

   state_t         state_q, state_d;
   logic [2:0]     op_q, op_d;
   logic           sgn_q, sgn_d, sres_q, sres_d;
   logic [W-1:0]   a_q, a_d, b_q, b_d, y_q, y_d;
   logic [AW-1:0]  acc_q, acc_d, x_q, x_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2*W-1:0] result_q, result_d;
   logic           neg_q, neg_d, ovf_q, ovf_d, err_q, err_d;

   logic [W-1:0]   mag_a, mag_b, sr, sr_abs;
   logic [AW-1:0]  mul_acc, div_sh, div_rem, fact_prod, mag;
   logic           div_ge, last, rneg, ferr;
   logic [W+1:0]   sa, sb, s_sum, s_abs;
   logic [2*W-1:0] ext_a, sl, sl_abs;

   always_comb begin
      mag_a     = (sgn && a[W-1]) ? -a : a;
      mag_b     = (sgn && b[W-1]) ? -b : b;
      mul_acc   = acc_q + (y_q[0] ? x_q : '0);
      // acc holds the partial remainder, x_q[W-1] is the next dividend bit
      div_sh    = {acc_q[AW-2:0], x_q[W-1]};
      div_ge    = div_sh >= AW'(y_q);
      div_rem   = div_ge ? div_sh - AW'(y_q) : div_sh;
      fact_prod = (x_q <= AW'(y_q)) ? acc_q * x_q : acc_q;
      sa        = sgn_q ? {{2{a_q[W-1]}}, a_q} : {2'b00, a_q};
      sb        = sgn_q ? {{2{b_q[W-1]}}, b_q} : {2'b00, b_q};
      s_sum     = (op_q == OP_SUB) ? sa - sb : sa + sb;
      s_abs     = s_sum[W+1] ? -s_sum : s_sum;
      if (int'(b_q) >= W)
         sr = (sgn_q && a_q[W-1]) ? '1 : '0;
      else if (sgn_q)
         sr = $signed(a_q) >>> b_q;
      else
         sr = a_q >> b_q;
      sr_abs    = (sgn_q && sr[W-1]) ? -sr : sr;
      ext_a     = sgn_q ? {{W{a_q[W-1]}}, a_q} : {{W{1'b0}}, a_q};
      sl        = (int'(b_q) >= W) ? '0 : ext_a << b_q;
      sl_abs    = (sgn_q && sl[2*W-1]) ? -sl : sl;
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      sgn_d    = sgn_q;
      sres_d   = sres_q;
      a_d      = a_q;
      b_d      = b_q;
      y_d      = y_q;
      acc_d    = acc_q;
      x_d      = x_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      neg_d    = neg_q;
      ovf_d    = ovf_q;
      err_d    = err_q;
      last     = 1'b0;
      mag      = '0;
      rneg     = 1'b0;
      ferr     = 1'b0;
      case (state_q)
         CALC: begin
            cnt_d = cnt_q - CW'(1);
            last  = (cnt_q == CW'(1));
            case (op_q)
               OP_ADD, OP_SUB: begin mag = AW'(s_abs); rneg = s_sum[W+1]; end
               OP_SHR:         begin mag = AW'(sr_abs); rneg = sr[W-1]; end
               OP_SHL:         begin mag = AW'(sl_abs); rneg = sl[2*W-1]; end
               OP_MUL: begin
                  acc_d = mul_acc;
                  x_d   = x_q << 1;
                  y_d   = y_q >> 1;
                  mag   = mul_acc;
                  rneg  = sres_q;
               end
               OP_DIV, OP_MOD: begin
                  acc_d = div_rem;
                  x_d   = {x_q[AW-2:0], div_ge};
                  mag   = (op_q == OP_DIV) ? AW'({x_q[W-2:0], div_ge}) : div_rem;
                  rneg  = sres_q;
                  ferr  = (y_q == '0);
               end
               default: begin
                  acc_d = fact_prod;
                  x_d   = x_q + AW'(1);
                  mag   = fact_prod;
                  ferr  = sgn_q & a_q[W-1];
                  if (fact_prod > AW'(LIMIT)) last = 1'b1;
               end
            endcase
            if (last) begin
               state_d  = FIN;
               result_d = '0;
               neg_d    = 1'b0;
               ovf_d    = 1'b0;
               err_d    = 1'b0;
               if (ferr)
                  err_d = 1'b1;
               else if (mag > AW'(LIMIT) || mag[AW-1:2*W] != '0)
                  ovf_d = 1'b1;  // magnitudes the result port cannot carry are unreportable too
               else begin
                  result_d = mag[2*W-1:0];
                  neg_d    = sgn_q & rneg & (mag != '0);
               end
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (start && (state_q != CALC)) begin
         state_d = CALC;
         op_d    = op;
         sgn_d   = sgn;
         a_d     = a;
         b_d     = b;
         acc_d   = '0;
         x_d     = AW'(mag_a);
         y_d     = mag_b;
         cnt_d   = CW'(1);
         sres_d  = sgn & (a[W-1] ^ b[W-1]);
         case (op)
            OP_MUL: cnt_d = CW'(W);
            OP_DIV: if (b != '0) cnt_d = CW'(W);
            OP_MOD: begin
               if (b != '0) cnt_d = CW'(W);
               sres_d = sgn & a[W-1];
            end
            OP_FACT: begin
               acc_d = AW'(1);
               x_d   = AW'(2);
               y_d   = mag_a;
               if (!(sgn && a[W-1]) && mag_a > W'(1)) cnt_d = CW'(mag_a) - CW'(1);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         op_q     <= '0;
         sgn_q    <= 1'b0;
         sres_q   <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         y_q      <= '0;
         acc_q    <= '0;
         x_q      <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         neg_q    <= 1'b0;
         ovf_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         sgn_q    <= sgn_d;
         sres_q   <= sres_d;
         a_q      <= a_d;
         b_q      <= b_d;
         y_q      <= y_d;
         acc_q    <= acc_d;
         x_q      <= x_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         neg_q    <= neg_d;
         ovf_q    <= ovf_d;
         err_q    <= err_d;
      end
   end

   assign busy   = (state_q == CALC);
   assign done   = (state_q == FIN);
   assign result = result_q;
   assign neg    = neg_q;
   assign ovf    = ovf_q;
   assign err    = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: a W=6 instance for most cases and a W=8
// instance for factorials and products that need the wider result port.
module tb_seq_alu;
   localparam int LIMIT = 9999;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start6, start8, sgn;
   logic [2:0]  op;
   logic [5:0]  a6, b6;
   logic [7:0]  a8, b8;
   logic        busy6, done6, neg6, ovf6, err6;
   logic        busy8, done8, neg8, ovf8, err8;
   logic [11:0] res6;
   logic [15:0] res8;

   seq_alu #(.W(6), .LIMIT(LIMIT)) dut6 (
      .clk(clk), .rst(rst), .start(start6), .op(op), .sgn(sgn), .a(a6), .b(b6),
      .busy(busy6), .done(done6), .result(res6), .neg(neg6), .ovf(ovf6), .err(err6));

   seq_alu #(.W(8), .LIMIT(LIMIT)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .op(op), .sgn(sgn), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .result(res8), .neg(neg8), .ovf(ovf8), .err(err8));

   typedef struct {
      string  tag;
      longint res;
      bit     neg, ovf, err;
      int     lat;
      int     t0;
   } exp_t;

   exp_t q6[$];
   exp_t q8[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input longint got, input longint want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", tag, got, want);
      end
   endtask

   function automatic exp_t model(input int w, input bit [2:0] o, input bit s,
                                  input longint av, input longint bv);
      exp_t   e;
      longint full, x, y, yu, v, mag, p;
      int     n, m;
      bit     er;
      full = longint'(1) << w;
      x = av & (full - 1);
      y = bv & (full - 1);
      yu = y;
      if (s && x >= full / 2) x -= full;
      if (s && y >= full / 2) y -= full;
      n = 1; v = 0; er = 0;
      case (o)
         3'd0: v = x + y;
         3'd1: v = x - y;
         3'd2: begin v = x * y; n = w; end
         3'd3: if (y == 0) er = 1; else begin v = x / y; n = w; end
         3'd4: if (y == 0) er = 1; else begin v = x % y; n = w; end
         3'd5: if (yu >= w) v = (s && x < 0) ? -1 : 0; else v = x >>> yu;
         3'd6: v = (yu >= w) ? 0 : x * (longint'(1) << yu);
         default: begin
            if (s && x < 0) er = 1;
            else begin
               p = 1; m = 1;
               for (int k = 2; k <= x; k++) begin
                  p = p * k; m = k;
                  if (p > LIMIT) break;
               end
               v = p;
               n = (m > 1) ? m - 1 : 1;
            end
         end
      endcase
      mag = (v < 0) ? -v : v;
      e.err = er; e.ovf = 0; e.res = 0; e.neg = 0;
      if (!er) begin
         if (mag > LIMIT || mag >= (longint'(1) << (2 * w))) e.ovf = 1;
         else begin
            e.res = mag;
            e.neg = s && (v < 0);
         end
      end
      e.lat = n + 1;
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (done6) begin
         if (q6.size() == 0) check_val("w6 done with empty queue", done6, 0);
         else begin
            e = q6.pop_front();
            check_val({e.tag, " result"}, res6, e.res);
            check_val({e.tag, " neg"}, neg6, e.neg);
            check_val({e.tag, " ovf"}, ovf6, e.ovf);
            check_val({e.tag, " err"}, err6, e.err);
            check_val({e.tag, " latency"}, cyc - e.t0, e.lat);
         end
      end
      if (done8) begin
         if (q8.size() == 0) check_val("w8 done with empty queue", done8, 0);
         else begin
            e = q8.pop_front();
            check_val({e.tag, " result"}, res8, e.res);
            check_val({e.tag, " neg"}, neg8, e.neg);
            check_val({e.tag, " ovf"}, ovf8, e.ovf);
            check_val({e.tag, " err"}, err8, e.err);
            check_val({e.tag, " latency"}, cyc - e.t0, e.lat);
         end
      end
   end

   task automatic issue(input bit w8, input bit [2:0] o, input bit s, input longint av,
                        input longint bv, input string tag, input bit push);
      exp_t e;
      e = model(w8 ? 8 : 6, o, s, av, bv);
      e.tag = tag;
      e.t0 = cyc;
      op = o;
      sgn = s;
      if (w8) begin
         a8 = av[7:0]; b8 = bv[7:0]; start8 = 1'b1;
         if (push) q8.push_back(e);
      end else begin
         a6 = av[5:0]; b6 = bv[5:0]; start6 = 1'b1;
         if (push) q6.push_back(e);
      end
      @(posedge clk); #1;
      start6 = 1'b0;
      start8 = 1'b0;
   endtask

   task automatic wait_done(input bit w8);
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!(w8 ? done8 : done6) && k < 300);
      if (k >= 300) check_val("done timeout", w8 ? done8 : done6, 1);
   endtask

   task automatic do_op(input bit w8, input bit [2:0] o, input bit s, input longint av,
                        input longint bv, input string tag);
      issue(w8, o, s, av, bv, tag, 1'b1);
      check_val({tag, " busy after accept"}, w8 ? busy8 : busy6, 1);
      wait_done(w8);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit [2:0] ro;
      bit       rs;
      rst = 1'b1; start6 = 1'b0; start8 = 1'b0; op = '0; sgn = 1'b0;
      a6 = '0; b6 = '0; a8 = '0; b8 = '0;
      repeat (3) @(posedge clk);
      #1;
      check_val("reset busy", busy6, 0);
      check_val("reset done", done6, 0);
      check_val("reset result", res6, 0);
      check_val("reset neg", neg6, 0);
      check_val("reset ovf", ovf6, 0);
      check_val("reset err", err6, 0);
      check_val("reset busy w8", busy8, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      do_op(0, 3'd0, 0, 63, 63, "add_u 63+63");
      repeat (3) @(negedge clk);
      check_val("result held", res6, 126);
      do_op(0, 3'd2, 1, -5, 7, "mul_s -5*7");
      do_op(0, 3'd3, 1, -17, 5, "div_s -17/5");
      do_op(0, 3'd4, 1, -17, 5, "mod_s -17%5");
      do_op(0, 3'd3, 0, 9, 0, "div 9/0");
      do_op(0, 3'd4, 1, -9, 0, "mod -9%0");
      do_op(0, 3'd7, 0, 5, 0, "fact 5");
      do_op(0, 3'd7, 0, 0, 0, "fact 0");
      do_op(0, 3'd7, 1, 1, 0, "fact 1");
      do_op(0, 3'd7, 0, 2, 0, "fact 2");
      do_op(0, 3'd7, 0, 6, 0, "fact 6");
      do_op(0, 3'd7, 1, -3, 0, "fact -3");
      do_op(0, 3'd1, 1, -32, 31, "sub_s -32-31");
      do_op(0, 3'd0, 1, -32, -32, "add_s -32+-32");
      do_op(0, 3'd5, 1, -32, 3, "shr_s -32>>3");
      do_op(0, 3'd5, 1, -5, 6, "shr_s -5>>6");
      do_op(0, 3'd5, 0, 40, 6, "shr_u 40>>6");
      do_op(0, 3'd5, 1, -7, 0, "shr_s -7>>0");
      do_op(0, 3'd6, 0, 63, 5, "shl_u 63<<5");
      do_op(0, 3'd6, 0, 1, 6, "shl_u 1<<6");
      do_op(0, 3'd6, 1, -3, 4, "shl_s -3<<4");
      do_op(0, 3'd2, 0, 63, 63, "mul_u 63*63");
      do_op(0, 3'd2, 1, 0, -5, "mul_s 0*-5");
      do_op(0, 3'd3, 1, -32, -1, "div_s -32/-1");

      for (int i = 0; i < 40; i++) begin
         ro = 3'($urandom_range(0, 7));
         rs = 1'($urandom_range(0, 1));
         do_op(0, ro, rs, longint'($urandom_range(0, 63)), longint'($urandom_range(0, 63)),
               $sformatf("rnd%0d op%0d s%0d", i, ro, rs));
         if ($urandom_range(0, 3) == 0) repeat (2) @(negedge clk);
      end

      do_op(1, 3'd7, 0, 7, 0, "w8 fact 7");
      do_op(1, 3'd7, 0, 8, 0, "w8 fact 8");
      do_op(1, 3'd2, 0, 255, 255, "w8 mul_u 255*255");
      do_op(1, 3'd2, 1, -100, 99, "w8 mul_s -100*99");
      repeat (2) @(negedge clk);

      issue(0, 3'd2, 1, -5, 7, "mul_s ignore start", 1'b1);
      @(posedge clk); #1;
      op = 3'd0; a6 = 6'd1; b6 = 6'd1; start6 = 1'b1;
      @(posedge clk); #1;
      start6 = 1'b0;
      wait_done(0);
      repeat (3) @(negedge clk);

      issue(0, 3'd2, 0, 9, 9, "mul aborted", 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check_val("abort busy", busy6, 0);
      check_val("abort done", done6, 0);
      check_val("abort result", res6, 0);
      rst = 1'b0;
      repeat (12) @(negedge clk);

      check_val("w6 queue drained", q6.size(), 0);
      check_val("w8 queue drained", q8.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
